ecc_rd_buffer: RTL and testbench

Read-return buffer directly downstream of the ECC decoder. It captures each decoded word and its error flag from the decoder's valid-only output. It holds them in a small FIFO and presents them to the consumer over a valid/ready handshake. It also provides a credit-style almost-full signal so the read issuer can throttle, since the decoder cannot be back-pressured. It keeps a saturating count of error-flagged words and a sticky overflow flag for words lost to a full buffer.

---
 rtl/ecc_pkg.sv | 25 ++
 rtl/ecc_rd_buffer_sat_counter.sv | 25 ++
 rtl/ecc_rd_buffer.sv | 110 +++++++++++
 tb/tb_ecc_rd_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC definitions: word/code widths, stored entry layout, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ecc_pkg;

    localparam int DATA_W = 32;
    localparam int CODE_W = 6;

    // One buffered read-return word together with its decoder error flag.
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Ceiling log2 usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ecc_rd_buffer_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
// Latency: count reflects an increment on the edge after inc is sampled.
// Backpressure: none; clr takes priority over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up until all-ones; clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ecc_rd_buffer.sv
// Read-return buffer behind the ECC decoder: small FIFO, error count, overflow flag.
// Latency: a word pushed at edge N is presented with out_vld=1 right after edge N.
// Backpressure: out_rdy stalls the consumer side only; the decoder side has no ready,
//   so words arriving at a full FIFO without a coincident pop are dropped (ovf set).
module ecc_rd_buffer
    import ecc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 2,
    parameter int CNT_W     = 16,
    localparam int PW       = clog2(DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    input  logic              in_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              almost_full,
    output logic [CW-1:0]     buf_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              ovf,
    input  logic              clr
);

    // Local entry layout follows the module's DATA_W, which may differ from the shared default.
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } buf_entry_t;

    buf_entry_t    mem [DEPTH];
    buf_entry_t    head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt_nxt;
    logic          push;
    logic          pop;
    logic          drop;

    // A pop frees its slot in the same cycle, so a full FIFO still accepts a word then.
    assign out_vld = (buf_cnt != '0);
    assign pop     = out_vld & out_rdy;
    assign push    = in_vld & ((buf_cnt < CW'(DEPTH)) | pop);
    assign drop    = in_vld & ~push;

    // Head is a plain register read; gated to zero while empty so idle outputs are clean.
    assign head     = mem[rd_ptr];
    assign out_data = out_vld ? head.data : '0;
    assign out_err  = out_vld ? head.err  : 1'b0;

    // Occupancy moves only when exactly one of push/pop happens.
    always_comb begin
        cnt_nxt = buf_cnt;
        if (push && !pop) begin
            cnt_nxt = buf_cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_nxt = buf_cnt - CW'(1);
        end
    end

    // Pointers, occupancy and the registered throttle hint.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            buf_cnt     <= '0;
            almost_full <= (DEPTH <= AF_MARGIN);
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            buf_cnt     <= cnt_nxt;
            almost_full <= ((CW'(DEPTH) - cnt_nxt) <= CW'(AF_MARGIN));
        end
    end

    // Storage write; contents are don't-care until referenced by a valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{err: in_err, data: in_data};
        end
    end

    // Sticky loss flag: a drop in the same cycle as clr keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr) begin
            ovf <= 1'b0;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (push & in_err),
        .clr   (clr),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_ecc_rd_buffer.sv
// Scoreboard bench for ecc_rd_buffer with DEPTH=4, AF_MARGIN=2, CNT_W=2.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge / after posedge.
// Backpressure: out_rdy driven directly by the stimulus.
module tb_ecc_rd_buffer;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 4;
    localparam int AF_MARGIN = 2;
    localparam int CNT_W     = 2;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int ERR_MAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_err;
    logic              in_vld;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              out_vld;
    logic              out_rdy;
    logic              almost_full;
    logic [CW-1:0]     buf_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              ovf;
    logic              clr;

    int tests;
    int errors;

    logic [DATA_W:0] sb[$];
    int              mcnt;
    int              merr;
    logic            movf;

    ecc_rd_buffer #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_err      (in_err),
        .in_vld      (in_vld),
        .out_data    (out_data),
        .out_err     (out_err),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .almost_full (almost_full),
        .buf_cnt     (buf_cnt),
        .err_cnt     (err_cnt),
        .ovf         (ovf),
        .clr         (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: compare the head on the negedge, advance the model, check state after the edge.
    task automatic step();
        logic            push_m;
        logic            pop_m;
        logic [DATA_W:0] e;
        @(negedge clk);
        chk("out_vld", 32'(out_vld), 32'(mcnt != 0));
        if (out_vld && out_rdy && !reset) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pop", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("pop_data", out_data, e[DATA_W-1:0]);
                chk("pop_err", 32'(out_err), 32'(e[DATA_W]));
            end
        end
        pop_m  = (mcnt != 0) && out_rdy;
        push_m = in_vld && ((mcnt < DEPTH) || pop_m);
        if (reset) begin
            sb.delete();
            mcnt = 0;
            merr = 0;
            movf = 1'b0;
        end else begin
            if (push_m) sb.push_back({in_err, in_data});
            mcnt = mcnt + int'(push_m) - int'(pop_m);
            if (clr) merr = 0;
            else if (push_m && in_err && merr != ERR_MAX) merr = merr + 1;
            if (in_vld && !push_m) movf = 1'b1;
            else if (clr) movf = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("buf_cnt", 32'(buf_cnt), 32'(mcnt));
        chk("err_cnt", 32'(err_cnt), 32'(merr));
        chk("ovf", 32'(ovf), 32'(movf));
        chk("almost_full", 32'(almost_full), 32'((DEPTH - mcnt) <= AF_MARGIN));
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic e,
                         input logic r, input logic c);
        in_vld  = v;
        in_data = d;
        in_err  = e;
        out_rdy = r;
        clr     = c;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && sb.size() != 0; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("drain_empty", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int exp_err [5];
        exp_err = '{1, 2, 3, 3, 3};
        tests   = 0;
        errors  = 0;
        mcnt    = 0;
        merr    = 0;
        movf    = 1'b0;
        reset   = 1'b1;
        in_vld  = 1'b0;
        in_data = '0;
        in_err  = 1'b0;
        out_rdy = 1'b0;
        clr     = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'(0));
        chk("rst_out_vld", 32'(out_vld), 32'(0));

        // Single word, one-cycle latency.
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        chk("single_vld", 32'(out_vld), 32'(1));
        chk("single_data", out_data, 32'hDEADBEEF);
        chk("single_err", 32'(out_err), 32'(0));
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("single_gone", 32'(out_vld), 32'(0));

        // Fill with consumer stalled; head must hold.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            chk("hold_data", out_data, 32'h1);
            if (i == 2) chk("af_after_2", 32'(almost_full), 32'(1));
        end
        chk("full_cnt", 32'(buf_cnt), 32'(4));
        drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
        chk("drop_ovf", 32'(ovf), 32'(1));
        chk("drop_cnt", 32'(buf_cnt), 32'(4));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr_alone_ovf", 32'(ovf), 32'(0));
        // Full with simultaneous push and pop.
        drive(1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
        chk("full_pp_cnt", 32'(buf_cnt), 32'(4));
        chk("full_pp_ovf", 32'(ovf), 32'(0));
        drain();

        // Saturating error count.
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 1'b1, 1'b1, 1'b0);
            chk("err_sat", 32'(err_cnt), 32'(exp_err[i]));
        end
        drain();

        // clr collisions.
        drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
        chk("clr_vs_inc", 32'(err_cnt), 32'(0));
        drain();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h3FF, 1'b0, 1'b0, 1'b1);
        chk("clr_vs_drop", 32'(ovf), 32'(1));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr_after_drop", 32'(ovf), 32'(0));
        drain();

        // Reset mid-stream with three words held.
        drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h401, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h402, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_cnt", 32'(buf_cnt), 32'(3));
        reset = 1'b1;
        drive(1'b1, 32'h403, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_cnt", 32'(buf_cnt), 32'(0));
        chk("mid_rst_vld", 32'(out_vld), 32'(0));
        chk("mid_rst_err", 32'(err_cnt), 32'(0));
        drive(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_ovf", 32'(ovf), 32'(0));
        reset = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
